// File: rtl/adap_pred_rec_sig_mc.sv
// Multi-channel reconstructed-signal stage of the ADPCM adaptive predictor.
// Each accepted sample yields SR = SE + DQ, its floating form SR0, and the
// partial-signal sign PK0 / zero flag SIGPK. Per-channel SR1/SR2 and
// PK1/PK2 delay lines are kept in small register files.
module adap_pred_rec_sig_mc #(
    parameter int NCH  = 4,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            scan_in0,
    input  logic            scan_en,
    output logic            scan_out0,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_ch,
    input  logic [14:0]     in_se,
    input  logic [14:0]     in_sez,
    input  logic [14:0]     in_dq,
    input  logic            clr_valid,
    input  logic [CH_W-1:0] clr_ch,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH_W-1:0] out_ch,
    output logic [15:0]     out_sr,
    output logic [10:0]     out_sr0,
    output logic [10:0]     out_sr1,
    output logic [10:0]     out_sr2,
    output logic            out_pk0,
    output logic            out_pk1,
    output logic            out_pk2,
    output logic            out_sigpk
);

    // Floating-point representation of a zero signal.
    localparam logic [10:0] SR_ZERO = 11'd32;

    logic [10:0] sr1_mem [NCH];
    logic [10:0] sr2_mem [NCH];
    logic        pk1_mem [NCH];
    logic        pk2_mem [NCH];

    logic        accept;
    logic        in_ok;
    logic        clr_ok;
    logic        hit_clr;
    logic        use_hist;
    logic [15:0] dqi;
    logic [15:0] sei;
    logic [15:0] sezi;
    logic [15:0] sr;
    logic [15:0] dqsez;
    logic        srs;
    logic [14:0] mag;
    logic [3:0]  expo;
    logic [5:0]  mant;
    logic [10:0] sr0;
    logic        pk0;
    logic        sigpk;
    logic [10:0] rd_sr1;
    logic [10:0] rd_sr2;
    logic        rd_pk1;
    logic        rd_pk2;
    logic        unused_scan;

    // Scan pins are stitched during synthesis; no functional role here.
    assign scan_out0   = 1'b0;
    assign unused_scan = scan_in0 ^ scan_en;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign in_ok    = 32'(in_ch) < NCH;
    assign clr_ok   = 32'(clr_ch) < NCH;

    // Sign-magnitude DQ to two's complement, then the two adders (ADDB/ADDC).
    always_comb begin
        dqi   = in_dq[14] ? (16'd0 - {2'b00, in_dq[13:0]}) : {2'b00, in_dq[13:0]};
        sei   = {in_se[14], in_se};
        sezi  = {in_sez[14], in_sez};
        sr    = dqi + sei;
        dqsez = dqi + sezi;
        pk0   = dqsez[15];
        sigpk = (dqsez == 16'd0);
    end

    // FLOATB: magnitude, exponent from the leading one, normalised mantissa.
    always_comb begin
        srs  = sr[15];
        mag  = srs ? 15'(16'd0 - sr) : sr[14:0];
        expo = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (mag[i]) begin
                expo = 4'(i + 1);
            end
        end
        mant = (mag == 15'd0) ? 6'd32 : 6'(({6'd0, mag} << 6) >> expo);
        sr0  = {srs, expo, mant};
    end

    // History read; a same-cycle clear of this channel forces the cleared view.
    always_comb begin
        hit_clr  = clr_valid && clr_ok && (clr_ch == in_ch);
        use_hist = in_ok && !hit_clr;
        rd_sr1   = SR_ZERO;
        rd_sr2   = SR_ZERO;
        rd_pk1   = 1'b0;
        rd_pk2   = 1'b0;
        if (use_hist) begin
            rd_sr1 = sr1_mem[in_ch];
            rd_sr2 = sr2_mem[in_ch];
            rd_pk1 = pk1_mem[in_ch];
            rd_pk2 = pk2_mem[in_ch];
        end
    end

    // Per-channel delay lines: an accept shifts the line, otherwise a clear resets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                sr1_mem[i] <= SR_ZERO;
                sr2_mem[i] <= SR_ZERO;
                pk1_mem[i] <= 1'b0;
                pk2_mem[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (accept && in_ok && (32'(in_ch) == i)) begin
                    sr2_mem[i] <= rd_sr1;
                    sr1_mem[i] <= sr0;
                    pk2_mem[i] <= rd_pk1;
                    pk1_mem[i] <= pk0;
                end else if (clr_valid && clr_ok && (32'(clr_ch) == i)) begin
                    sr1_mem[i] <= SR_ZERO;
                    sr2_mem[i] <= SR_ZERO;
                    pk1_mem[i] <= 1'b0;
                    pk2_mem[i] <= 1'b0;
                end
            end
        end
    end

    // Output register: loads on accept, holds while stalled, drops valid once consumed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_sr    <= 16'd0;
            out_sr0   <= 11'd0;
            out_sr1   <= 11'd0;
            out_sr2   <= 11'd0;
            out_pk0   <= 1'b0;
            out_pk1   <= 1'b0;
            out_pk2   <= 1'b0;
            out_sigpk <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            out_sr    <= sr;
            out_sr0   <= sr0;
            out_sr1   <= rd_sr1;
            out_sr2   <= rd_sr2;
            out_pk0   <= pk0;
            out_pk1   <= rd_pk1;
            out_pk2   <= rd_pk2;
            out_sigpk <= sigpk;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adap_pred_rec_sig_mc.sv
// Self-checking bench for adap_pred_rec_sig_mc: table-driven vectors, a
// per-channel history model and an expected-result queue, plus hand-written
// stall, clear and mid-stream reset sequences.
module tb_adap_pred_rec_sig_mc;

    localparam int NCH  = 4;
    localparam int CH_W = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            scan_in0;
    logic            scan_en;
    logic            scan_out0;
    logic            in_valid;
    logic            in_ready;
    logic [CH_W-1:0] in_ch;
    logic [14:0]     in_se;
    logic [14:0]     in_sez;
    logic [14:0]     in_dq;
    logic            clr_valid;
    logic [CH_W-1:0] clr_ch;
    logic            out_valid;
    logic            out_ready;
    logic [CH_W-1:0] out_ch;
    logic [15:0]     out_sr;
    logic [10:0]     out_sr0;
    logic [10:0]     out_sr1;
    logic [10:0]     out_sr2;
    logic            out_pk0;
    logic            out_pk1;
    logic            out_pk2;
    logic            out_sigpk;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [14:0]     se;
        logic [14:0]     sez;
        logic [14:0]     dq;
        logic [15:0]     sr;
        logic [10:0]     sr0;
        logic            pk0;
        logic            sigpk;
    } vec_t;

    typedef struct {
        logic [CH_W-1:0] ch;
        logic [15:0]     sr;
        logic [10:0]     sr0;
        logic [10:0]     sr1;
        logic [10:0]     sr2;
        logic            pk0;
        logic            pk1;
        logic            pk2;
        logic            sigpk;
    } exp_t;

    vec_t        vecs [11];
    exp_t        sb [$];
    logic [10:0] m_sr1 [NCH];
    logic [10:0] m_sr2 [NCH];
    logic        m_pk1 [NCH];
    logic        m_pk2 [NCH];
    logic [15:0] cur_sr;
    logic [10:0] cur_sr0;
    logic        cur_pk0;
    logic        cur_sigpk;
    bit          rand_ready;
    int          tests;
    int          fails;

    adap_pred_rec_sig_mc #(.NCH(NCH), .CH_W(CH_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .scan_in0  (scan_in0),
        .scan_en   (scan_en),
        .scan_out0 (scan_out0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_se     (in_se),
        .in_sez    (in_sez),
        .in_dq     (in_dq),
        .clr_valid (clr_valid),
        .clr_ch    (clr_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_sr    (out_sr),
        .out_sr0   (out_sr0),
        .out_sr1   (out_sr1),
        .out_sr2   (out_sr2),
        .out_pk0   (out_pk0),
        .out_pk1   (out_pk1),
        .out_pk2   (out_pk2),
        .out_sigpk (out_sigpk)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: signed 15-bit SE plus sign-magnitude DQ, modulo 2**16.
    function automatic logic [15:0] ref_sum(input logic [14:0] a, input logic [14:0] dq);
        int va;
        int vd;
        va = a[14] ? (int'(a) - 32768) : int'(a);
        vd = dq[14] ? -int'(dq[13:0]) : int'(dq[13:0]);
        return 16'(va + vd);
    endfunction

    // Reference floating conversion using the leading-one position via $clog2.
    function automatic logic [10:0] ref_float(input logic [15:0] s);
        int mag;
        int e;
        int m;
        mag = (s[15] ? (65536 - int'(s)) : int'(s)) & 32767;
        e   = (mag == 0) ? 0 : $clog2(mag + 1);
        m   = (mag == 0) ? 32 : ((mag * 64) >> e);
        return {s[15], 4'(e), 6'(m)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Drive one sample (optionally with a clear) and wait, bounded, for it to be accepted.
    task automatic applyStimulus(input logic [CH_W-1:0] ch, input logic [14:0] se,
                                 input logic [14:0] sez, input logic [14:0] dq,
                                 input logic [15:0] sr, input logic [10:0] sr0,
                                 input logic pk0, input logic sigpk,
                                 input logic clr, input logic [CH_W-1:0] cch);
        int n;
        bit acc;
        cur_sr    = sr;
        cur_sr0   = sr0;
        cur_pk0   = pk0;
        cur_sigpk = sigpk;
        in_ch     = ch;
        in_se     = se;
        in_sez    = sez;
        in_dq     = dq;
        clr_valid = clr;
        clr_ch    = cch;
        in_valid  = 1'b1;
        n   = 0;
        acc = 0;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            clr_valid = 1'b0;
            n++;
            if (rand_ready && !acc) out_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic applyRandom();
        logic [14:0]     se;
        logic [14:0]     sez;
        logic [14:0]     dq;
        logic [15:0]     s;
        logic [15:0]     z;
        logic [CH_W-1:0] ch;
        logic [CH_W-1:0] cch;
        logic            clr;
        se  = 15'($urandom_range(0, 32767));
        sez = 15'($urandom_range(0, 32767));
        dq  = 15'($urandom_range(0, 32767));
        ch  = CH_W'($urandom_range(0, NCH - 1));
        cch = CH_W'($urandom_range(0, NCH - 1));
        clr = ($urandom_range(0, 3) == 0);
        s   = ref_sum(se, dq);
        z   = ref_sum(sez, dq);
        out_ready = 1'($urandom_range(0, 2) != 0);
        applyStimulus(ch, se, sez, dq, s, ref_float(s), z[15], (z == 16'd0), clr, cch);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: pop and compare on consumption, push expectation on accept, track history.
    always @(negedge clk) begin
        exp_t e;
        bit   acc;
        bit   hit;
        if (!reset) begin
            sb.delete();
            for (int i = 0; i < NCH; i++) begin
                m_sr1[i] = 11'd32;
                m_sr2[i] = 11'd32;
                m_pk1[i] = 1'b0;
                m_pk2[i] = 1'b0;
            end
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("sb_ch",    32'(out_ch),    32'(e.ch));
                    checkOutput("sb_sr",    32'(out_sr),    32'(e.sr));
                    checkOutput("sb_sr0",   32'(out_sr0),   32'(e.sr0));
                    checkOutput("sb_sr1",   32'(out_sr1),   32'(e.sr1));
                    checkOutput("sb_sr2",   32'(out_sr2),   32'(e.sr2));
                    checkOutput("sb_pk0",   32'(out_pk0),   32'(e.pk0));
                    checkOutput("sb_pk1",   32'(out_pk1),   32'(e.pk1));
                    checkOutput("sb_pk2",   32'(out_pk2),   32'(e.pk2));
                    checkOutput("sb_sigpk", 32'(out_sigpk), 32'(e.sigpk));
                end
            end
            acc = in_valid && in_ready;
            hit = clr_valid && (clr_ch == in_ch);
            if (acc) begin
                e.ch    = in_ch;
                e.sr    = cur_sr;
                e.sr0   = cur_sr0;
                e.pk0   = cur_pk0;
                e.sigpk = cur_sigpk;
                e.sr1   = hit ? 11'd32 : m_sr1[in_ch];
                e.sr2   = hit ? 11'd32 : m_sr2[in_ch];
                e.pk1   = hit ? 1'b0 : m_pk1[in_ch];
                e.pk2   = hit ? 1'b0 : m_pk2[in_ch];
                sb.push_back(e);
            end
            if (clr_valid) begin
                m_sr1[clr_ch] = 11'd32;
                m_sr2[clr_ch] = 11'd32;
                m_pk1[clr_ch] = 1'b0;
                m_pk2[clr_ch] = 1'b0;
            end
            if (acc) begin
                m_sr2[in_ch] = e.sr1;
                m_sr1[in_ch] = e.sr0;
                m_pk2[in_ch] = e.pk1;
                m_pk1[in_ch] = e.pk0;
            end
        end
    end

    // Hard stop in case anything stalls indefinitely.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main test sequence.
    initial begin
        int n;
        vecs[0]  = '{2'd0, 15'd100,    15'd100,    15'd50,     16'd150,    11'd549,  1'b0, 1'b0};
        vecs[1]  = '{2'd0, 15'd100,    15'd100,    15'h4032,   16'd50,     11'd434,  1'b0, 1'b0};
        vecs[2]  = '{2'd1, 15'h7F9C,   15'h7F9C,   15'h4032,   16'hFF6A,   11'd1573, 1'b1, 1'b0};
        vecs[3]  = '{2'd1, 15'd0,      15'd0,      15'd0,      16'd0,      11'd32,   1'b0, 1'b1};
        vecs[4]  = '{2'd0, 15'd0,      15'h7FFF,   15'd1,      16'd1,      11'd96,   1'b0, 1'b1};
        vecs[5]  = '{2'd3, 15'h3FFF,   15'd0,      15'h3FFF,   16'h7FFE,   11'd1023, 1'b0, 1'b0};
        vecs[6]  = '{2'd3, 15'h4000,   15'h4000,   15'h7FFF,   16'h8001,   11'd2047, 1'b1, 1'b0};
        vecs[7]  = '{2'd2, 15'h4000,   15'd0,      15'h4000,   16'hC000,   11'd2016, 1'b0, 1'b1};
        vecs[8]  = '{2'd2, 15'd7,      15'd3,      15'h4005,   16'd2,      11'd160,  1'b1, 1'b0};
        vecs[9]  = '{2'd2, 15'd0,      15'd0,      15'h2000,   16'h2000,   11'd928,  1'b0, 1'b0};
        vecs[10] = '{2'd2, 15'h7FFF,   15'h7FFF,   15'd0,      16'hFFFF,   11'd1120, 1'b1, 1'b0};

        tests      = 0;
        fails      = 0;
        rand_ready = 0;
        reset      = 1'b0;
        scan_in0   = 1'b0;
        scan_en    = 1'b0;
        in_valid   = 1'b0;
        in_ch      = '0;
        in_se      = '0;
        in_sez     = '0;
        in_dq      = '0;
        clr_valid  = 1'b0;
        clr_ch     = '0;
        out_ready  = 1'b1;
        cur_sr     = '0;
        cur_sr0    = '0;
        cur_pk0    = 1'b0;
        cur_sigpk  = 1'b0;

        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sr",    32'(out_sr),    32'd0);
        checkOutput("rst_out_sr0",   32'(out_sr0),   32'd0);
        checkOutput("rst_out_sr1",   32'(out_sr1),   32'd0);
        checkOutput("rst_scan_out0", 32'(scan_out0), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors, back to back with the sink always ready.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].ch, vecs[i].se, vecs[i].sez, vecs[i].dq,
                          vecs[i].sr, vecs[i].sr0, vecs[i].pk0, vecs[i].sigpk, 1'b0, '0);
        end
        checkOutput("b2b_sr1_ch2", 32'(out_sr1), 32'd928);
        checkOutput("b2b_sr2_ch2", 32'(out_sr2), 32'd160);
        drain();

        // Stall: result held and input refused for three cycles.
        out_ready = 1'b0;
        applyStimulus(2'd2, 15'd1, 15'd1, 15'd1, 16'd2, 11'd160, 1'b0, 1'b0, 1'b0, '0);
        cur_sr    = 16'd3;
        cur_sr0   = 11'd176;
        cur_pk0   = 1'b0;
        cur_sigpk = 1'b0;
        in_ch     = 2'd2;
        in_se     = 15'd0;
        in_sez    = 15'd0;
        in_dq     = 15'd3;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("stall_in_ready",  32'(in_ready),  32'd0);
            checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_out_sr",    32'(out_sr),    32'd2);
            checkOutput("stall_out_sr0",   32'(out_sr0),   32'd160);
            checkOutput("stall_out_sr1",   32'(out_sr1),   32'd1120);
            checkOutput("stall_out_sr2",   32'(out_sr2),   32'd928);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("post_stall_sr0", 32'(out_sr0), 32'd176);
        checkOutput("post_stall_sr1", 32'(out_sr1), 32'd160);
        checkOutput("post_stall_sr2", 32'(out_sr2), 32'd1120);

        // Clear and accept on the same channel in the same cycle.
        applyStimulus(2'd0, 15'd10, 15'd10, 15'd10, 16'd20, 11'd360, 1'b0, 1'b0, 1'b1, 2'd0);
        checkOutput("clr_same_sr1", 32'(out_sr1), 32'd32);
        checkOutput("clr_same_sr2", 32'(out_sr2), 32'd32);
        checkOutput("clr_same_pk1", 32'(out_pk1), 32'd0);
        checkOutput("clr_same_pk2", 32'(out_pk2), 32'd0);
        applyStimulus(2'd0, 15'd0, 15'd0, 15'h4001, 16'hFFFF, 11'd1120, 1'b1, 1'b0, 1'b0, '0);
        checkOutput("after_clr_sr1", 32'(out_sr1), 32'd360);
        checkOutput("after_clr_sr2", 32'(out_sr2), 32'd32);

        // Clear of another channel leaves the accepted channel untouched.
        applyStimulus(2'd3, 15'h10, 15'd0, 15'd0, 16'd16, 11'd352, 1'b0, 1'b1, 1'b1, 2'd1);
        checkOutput("clr_other_sr1", 32'(out_sr1), 32'd2047);
        checkOutput("clr_other_sr2", 32'(out_sr2), 32'd1023);
        checkOutput("clr_other_pk1", 32'(out_pk1), 32'd1);
        applyStimulus(2'd1, 15'd0, 15'd0, 15'd0, 16'd0, 11'd32, 1'b0, 1'b1, 1'b0, '0);
        checkOutput("cleared_ch1_sr1", 32'(out_sr1), 32'd32);
        checkOutput("cleared_ch1_pk1", 32'(out_pk1), 32'd0);

        // Random traffic with random back-pressure and clears.
        rand_ready = 1;
        for (int i = 0; i < 80; i++) applyRandom();
        rand_ready = 0;
        drain();

        // Reset while a result is pending.
        out_ready = 1'b0;
        applyStimulus(2'd1, 15'd5, 15'd5, 15'd5, 16'd10, 11'd296, 1'b0, 1'b0, 1'b0, '0);
        checkOutput("pre_rst_valid", 32'(out_valid), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_sr",    32'(out_sr),    32'd0);
        checkOutput("mid_rst_sr0",   32'(out_sr0),   32'd0);
        checkOutput("mid_rst_sr1",   32'(out_sr1),   32'd0);
        checkOutput("mid_rst_ch",    32'(out_ch),    32'd0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_valid", 32'(out_valid), 32'd0);
        for (int c = 0; c < NCH; c++) begin
            applyStimulus(CH_W'(c), 15'd0, 15'd0, 15'd0, 16'd0, 11'd32, 1'b0, 1'b1, 1'b0, '0);
            checkOutput("post_rst_sr1", 32'(out_sr1), 32'd32);
            checkOutput("post_rst_sr2", 32'(out_sr2), 32'd32);
        end

        // Let every queued expectation be consumed.
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
